ibex_instr_req_ctrl: RTL and testbench
======================================

// Module: ibex_instr_req_ctrl
// PURPOSE
// - Instruction-bus request controller: issues word-aligned fetches, tracks up to NUM_REQS
//   outstanding, forwards in-order responses to the downstream fetch FIFO (in_* side).
// - On a branch: clears the FIFO, redirects fetching and discards responses of older requests.
// PARAMETERS
// - NUM_REQS  2  max outstanding bus requests (>=1); must equal the FIFO's NUM_REQS
// PORTS
// - clk_i           in   1   clock
// - rst_ni          in   1   reset, asynchronous, active-low
// - req_i           in   1   fetch enable from IF stage
// - branch_i        in   1   redirect strobe, single cycle
// - addr_i          in   32  branch target (halfword aligned)
// - fifo_ready_i    in   1   FIFO has space for NUM_REQS more words
// - fifo_valid_o    out  1   response word valid to FIFO
// - fifo_addr_o     out  32  = addr_i; sampled by FIFO only when fifo_clear_o
// - fifo_rdata_o    out  32  = instr_rdata_i
// - fifo_err_o      out  1   = instr_err_i
// - fifo_clear_o    out  1   = branch_i
// - instr_req_o     out  1   bus request
// - instr_gnt_i     in   1   bus grant
// - instr_addr_o    out  32  bus address, [1:0]=2'b00
// - instr_rvalid_i  in   1   bus response valid (in order)
// - instr_rdata_i   in   32  bus response data
// - instr_err_i     in   1   bus response error
// - busy_o          out  1   request pending or any response outstanding
// - stall_cnt_o     out  32  cycles instr_req_o=1 & instr_gnt_i=0 (see CONFIGURATION)
// BEHAVIOUR
// - Reset: instr_req_o=0, fetch_addr_q=0, outstanding cnt=0, discard bits=0, state IDLE,
//   busy_o=0, stall_cnt_o=0, fifo_valid_o=0 (no rvalid).
// - FSM IDLE: instr_req_o = (req_i|branch_i) & fifo_ready_i & cnt<NUM_REQS;
//   instr_addr_o = branch_i ? {addr_i[31:2],2'b00} : fetch_addr_q.
//   grant -> stay IDLE; no grant with req -> WAIT_GNT, latch issued addr in pend_addr_q.
// - WAIT_GNT: instr_req_o=1, instr_addr_o=pend_addr_q held stable regardless of branch_i,
//   req_i or fifo_ready_i; grant -> IDLE. No abort.
// - fetch_addr_q: branch_i -> {addr_i[31:2],2'b00}+4 if that target granted same cycle,
//   else {addr_i[31:2],2'b00}; grant of non-discarded request -> +4 (wraps at 2^32).
// - Branch in WAIT_GNT: set branch_pend_q; granted request recorded discard=1; fetch_addr_q
//   takes target; branch_pend_q clears on that grant.
// - Outstanding tracker: NUM_REQS-deep in-order queue of discard bits; push on grant,
//   pop on rvalid; grant+rvalid same cycle -> cnt unchanged; max cnt NUM_REQS.
// - Branch marks every outstanding entry discard=1 (including a same-cycle push of the
//   pre-branch request); a target request granted in the branch cycle pushes discard=0.
// - fifo_valid_o = instr_rvalid_i & ~discard_oldest & ~branch_i; zero added latency.
// - Discarded responses dropped silently, errors included.
// - rvalid with cnt=0 illegal (assertion). instr_req_o never depends on instr_gnt_i.
// - fifo_ready_i low blocks new requests only; responses still forwarded.
// CONFIGURATION
// - IBEX_INSTR_REQ_STALL_CNT_EN defined: 32-bit saturating counter, +1 each cycle
//   instr_req_o & ~instr_gnt_i, cleared by reset only, drives stall_cnt_o.
// - Undefined: no counter flops, stall_cnt_o tied to 32'd0.
// STRUCTURE
// - ibex_pkg: typedef enum logic {REQ_IDLE, REQ_WAIT_GNT} instr_req_state_e;
//   localparam int unsigned INSTR_WORD_BYTES = 4.
// - Sub-module ibex_instr_req_tracker: outstanding count + discard queue
//   (push, push_discard, pop, discard_all -> discard_oldest, full, empty).
// TESTING
// - Reset, req_i=1, branch_i pulse addr_i=0x100, gnt same cycle -> instr_addr_o=0x100,
//   fifo_clear_o=1, next request 0x104.
// - gnt held low 3 cycles -> instr_addr_o stable, stall_cnt_o=3 (macro on) / 0 (off).
// - NUM_REQS=2 granted, no rvalid -> instr_req_o=0 until rvalid; then cnt=1, req resumes.
// - 2 outstanding, branch to 0x202 -> both responses give fifo_valid_o=0; next request 0x200,
//   its response fifo_valid_o=1.
// - Branch to 0x300 in WAIT_GNT(0x104) -> addr stays 0x104 until gnt, response dropped,
//   then request 0x300.
// - Discarded rvalid with instr_err_i=1 -> fifo_valid_o=0; valid rvalid err=1 -> fifo_err_o=1.

Source files
------------

// File: rtl/ibex_pkg.sv
// rtl/ibex_pkg.sv - shared types and constants for the instruction request controller
package ibex_pkg;

    typedef enum logic {REQ_IDLE, REQ_WAIT_GNT} instr_req_state_e;

    localparam int unsigned INSTR_WORD_BYTES = 4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ibex_instr_req_tracker.sv
// rtl/ibex_instr_req_tracker.sv - in-order outstanding-request queue of discard bits
module ibex_instr_req_tracker #(
    parameter int unsigned NUM_REQS = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic i_push,
    input  logic i_push_discard,
    input  logic i_pop,
    input  logic i_discard_all,
    output logic o_discard_oldest,
    output logic o_full,
    output logic o_empty
);

    localparam int unsigned CW = $clog2(NUM_REQS + 1);

    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       w_cnt_pop;
    logic [CW-1:0]       w_cnt_next;
    logic [NUM_REQS-1:0] r_discard;
    logic [NUM_REQS-1:0] w_discard_next;
    logic [NUM_REQS:0]   w_ext;
    logic                w_pop;

    assign w_pop      = i_pop & (r_cnt != '0);
    assign w_cnt_pop  = r_cnt - CW'(w_pop);
    assign w_cnt_next = w_cnt_pop + CW'(i_push);
    assign w_ext      = {1'b0, r_discard};

    // Entry 0 is the oldest; a pop shifts down, a push lands just past the survivors.
    always_comb begin
        w_discard_next = r_discard;
        for (int i = 0; i < int'(NUM_REQS); i++) begin
            w_discard_next[i] = w_pop ? w_ext[i+1] : r_discard[i];
            if (i_discard_all) begin
                w_discard_next[i] = 1'b1;
            end
            if (i_push && (w_cnt_pop == CW'(i))) begin
                w_discard_next[i] = i_push_discard;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt     <= '0;
            r_discard <= '0;
        end else begin
            r_cnt     <= w_cnt_next;
            r_discard <= w_discard_next;
        end
    end

    assign o_discard_oldest = r_discard[0];
    assign o_full           = (r_cnt == CW'(NUM_REQS));
    assign o_empty          = (r_cnt == '0);

endmodule

// File: rtl/ibex_instr_req_ctrl.sv
// rtl/ibex_instr_req_ctrl.sv - instruction bus fetch request controller with branch discard
// Optional stall counter enabled by IBEX_INSTR_REQ_STALL_CNT_EN.
module ibex_instr_req_ctrl
    import ibex_pkg::*;
#(
    parameter int unsigned NUM_REQS = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] addr_i,
    input  logic        fifo_ready_i,
    output logic        fifo_valid_o,
    output logic [31:0] fifo_addr_o,
    output logic [31:0] fifo_rdata_o,
    output logic        fifo_err_o,
    output logic        fifo_clear_o,
    output logic        instr_req_o,
    input  logic        instr_gnt_i,
    output logic [31:0] instr_addr_o,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i,
    output logic        busy_o,
    output logic [31:0] stall_cnt_o
);

    instr_req_state_e r_state;
    instr_req_state_e w_state_next;
    logic [31:0]      r_fetch_addr;
    logic [31:0]      w_fetch_addr_next;
    logic [31:0]      r_pend_addr;
    logic [31:0]      w_target;
    logic             r_branch_pend;
    logic             w_branch_pend_next;
    logic             w_grant;
    logic             w_push_discard;
    logic             w_discard_oldest;
    logic             w_full;
    logic             w_empty;

    assign w_target = word_align(addr_i);

    always_comb begin
        w_state_next       = r_state;
        instr_req_o        = 1'b0;
        instr_addr_o       = r_fetch_addr;
        w_push_discard     = 1'b0;
        w_branch_pend_next = 1'b0;
        case (r_state)
            REQ_IDLE: begin
                instr_req_o  = (req_i | branch_i) & fifo_ready_i & ~w_full;
                instr_addr_o = branch_i ? w_target : r_fetch_addr;
                if (instr_req_o && !instr_gnt_i) begin
                    w_state_next = REQ_WAIT_GNT;
                end
            end
            REQ_WAIT_GNT: begin
                // The bus protocol forbids retracting a request, so the stale one rides out.
                instr_req_o    = 1'b1;
                instr_addr_o   = r_pend_addr;
                w_push_discard = r_branch_pend | branch_i;
                if (instr_gnt_i) begin
                    w_state_next = REQ_IDLE;
                end else begin
                    w_branch_pend_next = r_branch_pend | branch_i;
                end
            end
        endcase
    end

    assign w_grant = instr_req_o & instr_gnt_i;

    always_comb begin
        w_fetch_addr_next = r_fetch_addr;
        if (branch_i) begin
            if ((r_state == REQ_IDLE) && w_grant) begin
                w_fetch_addr_next = w_target + 32'(INSTR_WORD_BYTES);
            end else begin
                w_fetch_addr_next = w_target;
            end
        end else if (w_grant && !w_push_discard) begin
            w_fetch_addr_next = r_fetch_addr + 32'(INSTR_WORD_BYTES);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= REQ_IDLE;
            r_fetch_addr  <= '0;
            r_pend_addr   <= '0;
            r_branch_pend <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_fetch_addr  <= w_fetch_addr_next;
            r_branch_pend <= w_branch_pend_next;
            if ((r_state == REQ_IDLE) && (w_state_next == REQ_WAIT_GNT)) begin
                r_pend_addr <= instr_addr_o;
            end
        end
    end

    ibex_instr_req_tracker #(
        .NUM_REQS (NUM_REQS)
    ) u_tracker (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .i_push           (w_grant),
        .i_push_discard   (w_push_discard),
        .i_pop            (instr_rvalid_i),
        .i_discard_all    (branch_i),
        .o_discard_oldest (w_discard_oldest),
        .o_full           (w_full),
        .o_empty          (w_empty)
    );

    assign fifo_valid_o = instr_rvalid_i & ~w_discard_oldest & ~branch_i;
    assign fifo_addr_o  = addr_i;
    assign fifo_rdata_o = instr_rdata_i;
    assign fifo_err_o   = instr_err_i;
    assign fifo_clear_o = branch_i;
    assign busy_o       = instr_req_o | ~w_empty;

`ifdef IBEX_INSTR_REQ_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stall_cnt <= '0;
        end else if (instr_req_o && !instr_gnt_i && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`else
    assign stall_cnt_o = 32'd0;
`endif

    a_rvalid_outstanding: assert property (@(posedge clk_i) disable iff (!rst_ni)
        instr_rvalid_i |-> !w_empty);

endmodule

// File: tb/tb_ibex_instr_req_ctrl.sv
// tb/tb_ibex_instr_req_ctrl.sv - table-driven bench with response scoreboard for ibex_instr_req_ctrl
module tb_ibex_instr_req_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_i, branch_i, fifo_ready_i;
    logic [31:0] addr_i;
    logic        fifo_valid_o, fifo_err_o, fifo_clear_o;
    logic [31:0] fifo_addr_o, fifo_rdata_o;
    logic        instr_req_o, instr_gnt_i, instr_rvalid_i, instr_err_i;
    logic [31:0] instr_addr_o, instr_rdata_i;
    logic        busy_o;
    logic [31:0] stall_cnt_o;

    always #5 clk_i = ~clk_i;

    ibex_instr_req_ctrl #(.NUM_REQS(2)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_i          (req_i),
        .branch_i       (branch_i),
        .addr_i         (addr_i),
        .fifo_ready_i   (fifo_ready_i),
        .fifo_valid_o   (fifo_valid_o),
        .fifo_addr_o    (fifo_addr_o),
        .fifo_rdata_o   (fifo_rdata_o),
        .fifo_err_o     (fifo_err_o),
        .fifo_clear_o   (fifo_clear_o),
        .instr_req_o    (instr_req_o),
        .instr_gnt_i    (instr_gnt_i),
        .instr_addr_o   (instr_addr_o),
        .instr_rvalid_i (instr_rvalid_i),
        .instr_rdata_i  (instr_rdata_i),
        .instr_err_i    (instr_err_i),
        .busy_o         (busy_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    typedef struct {
        string       name;
        logic        req, branch;
        logic [31:0] addr;
        logic        ready, gnt, rvalid, err;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_busy, stale;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic        discard;
    } sb_t;

    sb_t sb[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    function automatic logic [31:0] resp_data(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic vec_t mk(input string name, input logic req, input logic branch,
                                input logic [31:0] addr, input logic ready, input logic gnt,
                                input logic rvalid, input logic err, input logic exp_req,
                                input logic [31:0] exp_addr, input logic exp_busy,
                                input logic stale);
        vec_t v;
        v.name = name; v.req = req; v.branch = branch; v.addr = addr; v.ready = ready;
        v.gnt = gnt; v.rvalid = rvalid; v.err = err; v.exp_req = exp_req;
        v.exp_addr = exp_addr; v.exp_busy = exp_busy; v.stale = stale;
        return v;
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Drive one cycle, check combinational outputs at the falling edge, update the scoreboard.
    task automatic apply(input vec_t v);
        sb_t  e;
        logic exp_fv;
        req_i          = v.req;
        branch_i       = v.branch;
        addr_i         = v.addr;
        fifo_ready_i   = v.ready;
        instr_gnt_i    = v.gnt;
        instr_rvalid_i = v.rvalid;
        instr_err_i    = v.err;
        instr_rdata_i  = 32'h0;
        if (v.rvalid && sb.size() > 0) begin
            instr_rdata_i = resp_data(sb[0].addr);
        end
        @(negedge clk_i);
        chk1({v.name, " req"}, instr_req_o, v.exp_req);
        if (v.exp_req) begin
            chk32({v.name, " addr"}, instr_addr_o, v.exp_addr);
        end
        chk1({v.name, " busy"}, busy_o, v.exp_busy);
        chk1({v.name, " clear"}, fifo_clear_o, v.branch);
        if (v.branch) begin
            foreach (sb[i]) sb[i].discard = 1'b1;
        end
        if (v.rvalid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s: rvalid driven with no outstanding request in scoreboard", v.name);
            end else begin
                e      = sb.pop_front();
                exp_fv = !e.discard && !v.branch;
                chk1({v.name, " fifo_valid"}, fifo_valid_o, exp_fv);
                if (exp_fv) begin
                    chk32({v.name, " rdata"}, fifo_rdata_o, resp_data(e.addr));
                    chk1({v.name, " err"}, fifo_err_o, v.err);
                end
            end
        end else begin
            chk1({v.name, " fifo_valid idle"}, fifo_valid_o, 1'b0);
        end
        if (v.exp_req && v.gnt) begin
            e.addr    = v.exp_addr;
            e.discard = v.stale;
            sb.push_back(e);
        end
        @(posedge clk_i);
        #1;
    endtask

    vec_t tbl[11];
    vec_t seq[$];
    logic [31:0] exp_stall;

    initial begin
        //            name        req br addr          rdy gnt rv err  xreq xaddr         busy stale
        tbl[0]  = mk("br100",     1, 1, 32'h100,      1,  1,  0, 0,   1, 32'h100,      1,   0);
        tbl[1]  = mk("seq104",    1, 0, 32'h0,        1,  1,  0, 0,   1, 32'h104,      1,   0);
        tbl[2]  = mk("full",      1, 0, 32'h0,        1,  0,  0, 0,   0, 32'h0,        1,   0);
        tbl[3]  = mk("rsp_full",  1, 0, 32'h0,        1,  0,  1, 0,   0, 32'h0,        1,   0);
        tbl[4]  = mk("wait0",     1, 0, 32'h0,        1,  0,  0, 0,   1, 32'h108,      1,   0);
        tbl[5]  = mk("wait1",     1, 0, 32'h0,        1,  0,  0, 0,   1, 32'h108,      1,   0);
        tbl[6]  = mk("wait2",     0, 0, 32'h0,        0,  0,  0, 0,   1, 32'h108,      1,   0);
        tbl[7]  = mk("gnt108",    1, 0, 32'h0,        1,  1,  0, 0,   1, 32'h108,      1,   0);
        tbl[8]  = mk("rsp104",    0, 0, 32'h0,        1,  0,  1, 0,   0, 32'h0,        1,   0);
        tbl[9]  = mk("rsp108",    0, 0, 32'h0,        1,  0,  1, 0,   0, 32'h0,        1,   0);
        tbl[10] = mk("idle",      0, 0, 32'h0,        1,  0,  0, 0,   0, 32'h0,        0,   0);

        rst_ni = 1'b0; req_i = 0; branch_i = 0; addr_i = 0; fifo_ready_i = 1;
        instr_gnt_i = 0; instr_rvalid_i = 0; instr_rdata_i = 0; instr_err_i = 0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk1("rst req", instr_req_o, 1'b0);
        chk1("rst busy", busy_o, 1'b0);
        chk1("rst fifo_valid", fifo_valid_o, 1'b0);
        chk32("rst stall", stall_cnt_o, 32'h0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        for (int i = 0; i < 11; i++) apply(tbl[i]);
`ifdef IBEX_INSTR_REQ_STALL_CNT_EN
        exp_stall = 32'd3;
`else
        exp_stall = 32'd0;
`endif
        chk32("stall_cnt", stall_cnt_o, exp_stall);

        // Branch with two outstanding, then branch while waiting for grant, wrap, ready low.
        seq.push_back(mk("a10c",      1, 0, 32'h0,        1, 1, 0, 0, 1, 32'h10C,      1, 0));
        seq.push_back(mk("a110",      1, 0, 32'h0,        1, 1, 0, 0, 1, 32'h110,      1, 0));
        seq.push_back(mk("br202",     1, 1, 32'h202,      1, 0, 0, 0, 0, 32'h0,        1, 0));
        seq.push_back(mk("drop0",     0, 0, 32'h0,        1, 0, 1, 0, 0, 32'h0,        1, 0));
        seq.push_back(mk("drop1err",  0, 0, 32'h0,        1, 0, 1, 1, 0, 32'h0,        1, 0));
        seq.push_back(mk("a200",      1, 0, 32'h0,        1, 1, 0, 0, 1, 32'h200,      1, 0));
        seq.push_back(mk("rsp200",    0, 0, 32'h0,        1, 0, 1, 0, 0, 32'h0,        1, 0));
        seq.push_back(mk("br104wait", 1, 1, 32'h104,      1, 0, 0, 0, 1, 32'h104,      1, 0));
        seq.push_back(mk("br300held", 1, 1, 32'h300,      1, 0, 0, 0, 1, 32'h104,      1, 0));
        seq.push_back(mk("held104",   1, 0, 32'h0,        1, 0, 0, 0, 1, 32'h104,      1, 0));
        seq.push_back(mk("gnt104st",  1, 0, 32'h0,        1, 1, 0, 0, 1, 32'h104,      1, 1));
        seq.push_back(mk("a300",      1, 0, 32'h0,        1, 1, 0, 0, 1, 32'h300,      1, 0));
        seq.push_back(mk("drop104",   0, 0, 32'h0,        1, 0, 1, 0, 0, 32'h0,        1, 0));
        seq.push_back(mk("rsp300err", 0, 0, 32'h0,        1, 0, 1, 1, 0, 32'h0,        1, 0));
        seq.push_back(mk("idle2",     0, 0, 32'h0,        1, 0, 0, 0, 0, 32'h0,        0, 0));
        seq.push_back(mk("a304",      1, 0, 32'h0,        1, 1, 0, 0, 1, 32'h304,      1, 0));
        seq.push_back(mk("notready",  1, 0, 32'h0,        0, 0, 1, 0, 0, 32'h0,        1, 0));
        seq.push_back(mk("idle3",     0, 0, 32'h0,        1, 0, 0, 0, 0, 32'h0,        0, 0));
        seq.push_back(mk("brwrap",    1, 1, 32'hFFFF_FFFE, 1, 1, 0, 0, 1, 32'hFFFF_FFFC, 1, 0));
        seq.push_back(mk("wrap0",     1, 0, 32'h0,        1, 1, 0, 0, 1, 32'h0,        1, 0));
        seq.push_back(mk("rspfffc",   0, 0, 32'h0,        1, 0, 1, 0, 0, 32'h0,        1, 0));
        seq.push_back(mk("rsp0",      0, 0, 32'h0,        1, 0, 1, 0, 0, 32'h0,        1, 0));
        seq.push_back(mk("wait4",     1, 0, 32'h0,        1, 0, 0, 0, 1, 32'h4,        1, 0));
        seq.push_back(mk("brgnt400",  1, 1, 32'h400,      1, 1, 0, 0, 1, 32'h4,        1, 1));
        seq.push_back(mk("a400",      1, 0, 32'h0,        1, 1, 0, 0, 1, 32'h400,      1, 0));
        seq.push_back(mk("drop4",     0, 0, 32'h0,        1, 0, 1, 1, 0, 32'h0,        1, 0));
        seq.push_back(mk("rsp400",    0, 0, 32'h0,        1, 0, 1, 0, 0, 32'h0,        1, 0));
        seq.push_back(mk("idle4",     0, 0, 32'h0,        1, 0, 0, 0, 0, 32'h0,        0, 0));
        foreach (seq[i]) apply(seq[i]);

        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d entries left expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
